// File: rtl/kiwi_cpu_bus.sv
// kiwi_cpu_bus: Z80 main-CPU bus glue (decode, banked ROM address, read mux, bank latch, VBL irq, ROM wait, shared RAM)
// Ports: clk/rst (async, active-high); cen6 -> cpu_cen (ROM wait gating);
//   Z80 bus: a, cpu_dout, mreq_n, iorq_n, m1_n, wr_n -> cpu_din, int_n;
//   ROM: rom_addr, rom_cs, rom_ok, rom_data; video: vram_cs, vctrl_cs, pal_cs, vram_dout, pal_dout;
//   latch: bank, snd_rstn; sound-side shared RAM port: shr_addr, shr_din, shr_we -> shr_dout.
// Build option: IRQ_M1_QUAL_EN qualifies the interrupt acknowledge with m1_n.
module kiwi_cpu_bus (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  output logic        cpu_cen,
  input  logic        lvbl,
  input  logic [15:0] a,
  input  logic [7:0]  cpu_dout,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        wr_n,
  output logic [7:0]  cpu_din,
  output logic        int_n,
  output logic [16:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [7:0]  rom_data,
  output logic        vram_cs,
  output logic        vctrl_cs,
  output logic        pal_cs,
  input  logic [7:0]  vram_dout,
  input  logic [7:0]  pal_dout,
  output logic        snd_rstn,
  output logic [2:0]  bank,
  input  logic [12:0] shr_addr,
  input  logic [7:0]  shr_din,
  input  logic        shr_we,
  output logic [7:0]  shr_dout
);
  logic rom_cs_d, vram_cs_d, ram_cs_d, vctrl_cs_d, bank_cs_d, pal_cs_d;
  logic rom_cs_q, vram_cs_q, ram_cs_q, vctrl_cs_q, bank_cs_q, pal_cs_q;
  logic [7:0] cpu_din_d, cpu_din_q, ram_a_q, ram_b_q;
  logic [2:0] bank_d, bank_q;
  logic snd_rstn_d, snd_rstn_q, irq_d, irq_q, lvbl_q, lvbl_qq, irq_ack, ram_we;
  logic [7:0] mem [8192];
  logic unused;
  assign unused = &{1'b0, m1_n, cpu_dout[7:5], cpu_dout[3]};
  always_comb begin
    rom_cs_d   = ~mreq_n & (a < 16'hC000);
    vram_cs_d  = ~mreq_n & (a[15:13] == 3'b110);
    ram_cs_d   = ~mreq_n & (a[15:12] == 4'hE);
    vctrl_cs_d = ~mreq_n & (a[15:12] == 4'hF) & (a[11:8] < 4'h6);
    bank_cs_d  = ~mreq_n & (a[15:8] == 8'hF6);
    pal_cs_d   = ~mreq_n & (a[15:8] == 8'hF8);
  end
`ifdef IRQ_M1_QUAL_EN
  assign irq_ack = ~iorq_n & ~m1_n;
`else
  assign irq_ack = ~iorq_n;
`endif
  always_comb begin
    cpu_din_d  = rom_cs_q ? rom_data : ram_cs_q ? ram_a_q : vram_cs_q ? vram_dout : pal_cs_q ? pal_dout : 8'hFF;
    bank_d     = (bank_cs_q & ~wr_n) ? cpu_dout[2:0] : bank_q;
    snd_rstn_d = (bank_cs_q & ~wr_n) ? cpu_dout[4] : snd_rstn_q;
    // acknowledge wins over a same-cycle falling edge of the registered lvbl
    irq_d      = irq_ack ? 1'b0 : (lvbl_qq & ~lvbl_q) ? 1'b1 : irq_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rom_cs_q, vram_cs_q, ram_cs_q, vctrl_cs_q, bank_cs_q, pal_cs_q} <= '0;
      cpu_din_q  <= 8'hFF;
      bank_q     <= 3'd0;
      snd_rstn_q <= 1'b0;
      irq_q      <= 1'b0;
      lvbl_q     <= 1'b1;
      lvbl_qq    <= 1'b1;
    end else begin
      {rom_cs_q, vram_cs_q, ram_cs_q, vctrl_cs_q, bank_cs_q, pal_cs_q} <=
        {rom_cs_d, vram_cs_d, ram_cs_d, vctrl_cs_d, bank_cs_d, pal_cs_d};
      cpu_din_q  <= cpu_din_d;
      bank_q     <= bank_d;
      snd_rstn_q <= snd_rstn_d;
      irq_q      <= irq_d;
      lvbl_q     <= lvbl;
      lvbl_qq    <= lvbl_q;
    end
  end
  // Write address follows the live bus while the select is the registered one,
  // so the write lands one clk into the access. Port B is written last and wins collisions.
  assign ram_we = ram_cs_q & ~wr_n;
  always_ff @(posedge clk) begin
    if (ram_we) mem[a[12:0]] <= cpu_dout;
    if (shr_we) mem[shr_addr] <= shr_din;
    ram_a_q <= mem[a[12:0]];
    ram_b_q <= mem[shr_addr];
  end
  // Upper half of the map selects bank+1 so bank 0 still reaches ROM above 0x8000
  assign rom_addr = a[15] ? {bank_q + 3'd1, a[13:0]} : {2'b00, a[14:0]};
  assign cpu_cen  = cen6 & ~(rom_cs_q & ~rom_ok);
  assign rom_cs   = rom_cs_q;
  assign vram_cs  = vram_cs_q;
  assign vctrl_cs = vctrl_cs_q;
  assign pal_cs   = pal_cs_q;
  assign cpu_din  = cpu_din_q;
  assign bank     = bank_q;
  assign snd_rstn = snd_rstn_q;
  assign int_n    = ~irq_q;
  assign shr_dout = ram_b_q;
endmodule

// File: tb/tb_kiwi_cpu_bus.sv
// tb_kiwi_cpu_bus: scenario tasks with a behavioural model of the memory map, bank latch and shared RAM
module tb_kiwi_cpu_bus;
  logic clk = 0, rst = 1, cen6 = 1, lvbl = 1, mreq_n = 1, iorq_n = 1, m1_n = 1, wr_n = 1;
  logic rom_ok = 1, shr_we = 0;
  logic [15:0] a = 0;
  logic [7:0] cpu_dout = 0, rom_data = 0, vram_dout = 0, pal_dout = 0, shr_din = 0;
  logic [12:0] shr_addr = 0;
  logic cpu_cen, int_n, rom_cs, vram_cs, vctrl_cs, pal_cs, snd_rstn;
  logic [7:0] cpu_din, shr_dout;
  logic [16:0] rom_addr;
  logic [2:0] bank;
  int total = 0, bad = 0;
  int bk = 0;
  logic snd = 0;
  logic [7:0] mem_m [8192];
  logic [12:0] kq [$];

  kiwi_cpu_bus dut (
    .clk(clk), .rst(rst), .cen6(cen6), .cpu_cen(cpu_cen), .lvbl(lvbl), .a(a),
    .cpu_dout(cpu_dout), .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .wr_n(wr_n),
    .cpu_din(cpu_din), .int_n(int_n), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .rom_data(rom_data), .vram_cs(vram_cs), .vctrl_cs(vctrl_cs),
    .pal_cs(pal_cs), .vram_dout(vram_dout), .pal_dout(pal_dout), .snd_rstn(snd_rstn),
    .bank(bank), .shr_addr(shr_addr), .shr_din(shr_din), .shr_we(shr_we), .shr_dout(shr_dout)
  );

  always #5 clk = ~clk;

  // 0 none, 1 rom, 2 vram, 3 ram, 4 vctrl, 5 bank latch, 6 palette
  function automatic int sel_of(input logic [15:0] ad, input logic mq);
    if (mq) return 0;
    if (ad < 16'hC000) return 1;
    if (ad < 16'hE000) return 2;
    if (ad < 16'hF000) return 3;
    if (ad < 16'hF600) return 4;
    if (ad < 16'hF700) return 5;
    if (ad >= 16'hF800 && ad < 16'hF900) return 6;
    return 0;
  endfunction

  function automatic logic [16:0] ea_of(input logic [15:0] ad, input int b);
    int r;
    if (ad < 16'h8000) return 17'(ad);
    r = ((b + 1) % 8) * 16384 + (int'(ad) % 16384);
    return 17'(r);
  endfunction

  task automatic main_wr(input logic [15:0] ad, input logic [7:0] d);
    a = ad; mreq_n = 0; wr_n = 0; cpu_dout = d;
    @(negedge clk); @(negedge clk);
    mreq_n = 1; wr_n = 1;
    if (sel_of(ad, 0) == 3) begin mem_m[ad[12:0]] = d; kq.push_back(ad[12:0]); end
    if (sel_of(ad, 0) == 5) begin bk = d % 8; snd = d[4]; end
  endtask

  task automatic snd_wr(input logic [12:0] ad, input logic [7:0] d);
    shr_addr = ad; shr_din = d; shr_we = 1;
    @(negedge clk);
    shr_we = 0;
    mem_m[ad] = d; kq.push_back(ad);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++; if ({rom_cs, vram_cs, vctrl_cs, pal_cs} !== 4'b0) begin bad++; $display("FAIL reset_sel got=%b want=0000", {rom_cs, vram_cs, vctrl_cs, pal_cs}); end
    total++; if (bank !== 3'd0 || snd_rstn !== 1'b0) begin bad++; $display("FAIL reset_latch bank=%0d snd_rstn=%b want 0/0", bank, snd_rstn); end
    total++; if (int_n !== 1'b1) begin bad++; $display("FAIL reset_int_n got=%b want=1", int_n); end
    total++; if (cpu_din !== 8'hFF) begin bad++; $display("FAIL reset_cpu_din got=%h want=ff", cpu_din); end
  endtask

  task automatic test_shared_ram();
    logic [12:0] ad;
    logic [7:0] d;
    main_wr(16'hE010, 8'h5A); @(negedge clk);
    shr_addr = 13'h0010; @(negedge clk);
    total++; if (shr_dout !== 8'h5A) begin bad++; $display("FAIL ram_main_to_snd got=%h want=5a", shr_dout); end
    snd_wr(13'h1FFF, 8'hA5);
    a = 16'hFFFF; mreq_n = 0; @(negedge clk); @(negedge clk);
    total++; if (cpu_din !== 8'hFF) begin bad++; $display("FAIL ram_ffff_not_ram got=%h want=ff", cpu_din); end
    mreq_n = 1;
    snd_wr(13'h0011, 8'h3C);
    a = 16'hE011; mreq_n = 0; @(negedge clk); @(negedge clk);
    total++; if (cpu_din !== 8'h3C) begin bad++; $display("FAIL ram_snd_to_main got=%h want=3c", cpu_din); end
    mreq_n = 1; @(negedge clk);
    a = 16'hE020; mreq_n = 0; wr_n = 0; cpu_dout = 8'h11; @(negedge clk);
    shr_addr = 13'h0020; shr_din = 8'h99; shr_we = 1; @(negedge clk);
    mreq_n = 1; wr_n = 1; shr_we = 0; mem_m[13'h20] = 8'h99; kq.push_back(13'h20); @(negedge clk);
    total++; if (shr_dout !== 8'h99) begin bad++; $display("FAIL ram_collision got=%h want=99", shr_dout); end
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin d = 8'($urandom); main_wr(16'hE000 | 16'($urandom_range(0, 4095)), d); @(negedge clk); end
        1: snd_wr(13'($urandom), 8'($urandom));
        default: begin
          ad = kq[$urandom_range(0, kq.size() - 1)];
          if (ad < 13'h1000 && $urandom_range(0, 1) == 1) begin
            a = 16'hE000 | 16'(ad); mreq_n = 0; @(negedge clk); @(negedge clk);
            total++; if (cpu_din !== mem_m[ad]) begin bad++; $display("FAIL ram_rand_main addr=%h got=%h want=%h", ad, cpu_din, mem_m[ad]); end
            mreq_n = 1; @(negedge clk);
          end else begin
            shr_addr = ad; @(negedge clk);
            total++; if (shr_dout !== mem_m[ad]) begin bad++; $display("FAIL ram_rand_snd addr=%h got=%h want=%h", ad, shr_dout, mem_m[ad]); end
          end
        end
      endcase
    end
  endtask

  task automatic test_decode();
    logic [15:0] list [7];
    logic [15:0] ad;
    logic mq;
    int s;
    logic [7:0] rd, vd, pd, ed;
    list = '{16'h0000, 16'hBFFF, 16'hC000, 16'hE123, 16'hF5FF, 16'hF800, 16'hF700};
    for (int i = 0; i < 60; i++) begin
      ad = i < 7 ? list[i] : 16'($urandom);
      mq = i < 7 ? 1'b0 : ($urandom_range(0, 4) == 0);
      rd = 8'($urandom); vd = 8'($urandom); pd = 8'($urandom);
      a = ad; mreq_n = mq; wr_n = 1; rom_data = rd; vram_dout = vd; pal_dout = pd;
      #1;
      total++; if (rom_addr !== ea_of(ad, bk)) begin bad++; $display("FAIL dec_rom_addr a=%h got=%h want=%h", ad, rom_addr, ea_of(ad, bk)); end
      @(negedge clk);
      s = sel_of(ad, mq);
      total++;
      if ({rom_cs, vram_cs, vctrl_cs, pal_cs} !== {s == 1, s == 2, s == 4, s == 6}) begin
        bad++; $display("FAIL dec_sel a=%h mreq_n=%b got=%b want=%b", ad, mq, {rom_cs, vram_cs, vctrl_cs, pal_cs}, {s == 1, s == 2, s == 4, s == 6});
      end
      @(negedge clk);
      ed = s == 1 ? rd : s == 2 ? vd : s == 6 ? pd : s == 3 ? mem_m[ad[12:0]] : 8'hFF;
      if (s != 3 || ad[12:0] inside {kq}) begin
        total++; if (cpu_din !== ed) begin bad++; $display("FAIL dec_cpu_din a=%h got=%h want=%h", ad, cpu_din, ed); end
      end
    end
    mreq_n = 1; @(negedge clk);
  endtask

  task automatic test_bank();
    logic [7:0] d;
    logic [15:0] ad;
    main_wr(16'hF600, 8'h13);
    total++; if (bank !== 3'd3 || snd_rstn !== 1'b1) begin bad++; $display("FAIL bank_13 bank=%0d snd_rstn=%b want 3/1", bank, snd_rstn); end
    @(negedge clk); a = 16'h8005; #1;
    total++; if (rom_addr !== 17'h10005) begin bad++; $display("FAIL bank_13_addr got=%h want=10005", rom_addr); end
    main_wr(16'hF600, 8'h07); @(negedge clk); a = 16'h8005; #1;
    total++; if (rom_addr !== 17'h00005) begin bad++; $display("FAIL bank_07_addr got=%h want=00005", rom_addr); end
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      main_wr(16'hF600 | 16'($urandom_range(0, 255)), d);
      total++; if (bank !== 3'(bk) || snd_rstn !== snd) begin bad++; $display("FAIL bank_rand d=%h bank=%0d snd_rstn=%b want %0d/%b", d, bank, snd_rstn, bk, snd); end
      @(negedge clk);
      ad = 16'h8000 | 16'($urandom);
      a = ad; #1;
      total++; if (rom_addr !== ea_of(ad, bk)) begin bad++; $display("FAIL bank_rand_addr a=%h got=%h want=%h", ad, rom_addr, ea_of(ad, bk)); end
    end
  endtask

  task automatic test_irq();
    lvbl = 1; repeat (3) @(negedge clk);
    lvbl = 0; @(negedge clk);
    total++; if (int_n !== 1'b1) begin bad++; $display("FAIL irq_early got=%b want=1", int_n); end
    @(negedge clk);
    total++; if (int_n !== 1'b0) begin bad++; $display("FAIL irq_set got=%b want=0", int_n); end
    iorq_n = 0; m1_n = 0; @(negedge clk);
    total++; if (int_n !== 1'b1) begin bad++; $display("FAIL irq_ack got=%b want=1", int_n); end
    iorq_n = 1; m1_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (int_n !== 1'b1) begin bad++; $display("FAIL irq_retrigger cyc=%0d got=%b want=1", i, int_n); end
    end
    lvbl = 1; repeat (3) @(negedge clk);
    lvbl = 0; @(negedge clk);
    iorq_n = 0; m1_n = 0; @(negedge clk);
    iorq_n = 1; m1_n = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (int_n !== 1'b1) begin bad++; $display("FAIL irq_ack_vs_set cyc=%0d got=%b want=1", i, int_n); end
      @(negedge clk);
    end
    lvbl = 1; repeat (3) @(negedge clk);
  endtask

  task automatic test_wait();
    a = 16'h1234; mreq_n = 0; rom_ok = 0; @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cen6 = 1'($urandom_range(0, 1)) | (i == 0); #1;
      total++; if (cpu_cen !== 1'b0) begin bad++; $display("FAIL wait_stall cyc=%0d got=%b want=0", i, cpu_cen); end
      @(negedge clk);
    end
    rom_ok = 1;
    for (int i = 0; i < 4; i++) begin
      cen6 = i[0]; #1;
      total++; if (cpu_cen !== cen6) begin bad++; $display("FAIL wait_release cyc=%0d got=%b want=%b", i, cpu_cen, cen6); end
      @(negedge clk);
    end
    a = 16'hC000; rom_ok = 0; @(negedge clk); cen6 = 1; #1;
    total++; if (cpu_cen !== 1'b1) begin bad++; $display("FAIL wait_non_rom got=%b want=1", cpu_cen); end
    rom_ok = 1; mreq_n = 1; @(negedge clk);
  endtask

  task automatic test_reset_mid();
    main_wr(16'hF600, 8'h15); @(negedge clk);
    lvbl = 0; @(negedge clk); @(negedge clk);
    total++; if (int_n !== 1'b0 || bank !== 3'd5 || snd_rstn !== 1'b1) begin bad++; $display("FAIL rstmid_pre int_n=%b bank=%0d snd_rstn=%b want 0/5/1", int_n, bank, snd_rstn); end
    a = 16'h0100; mreq_n = 0; @(negedge clk);
    #2 rst = 1; #1;
    total++; if (int_n !== 1'b1 || bank !== 3'd0 || snd_rstn !== 1'b0) begin bad++; $display("FAIL rstmid_async int_n=%b bank=%0d snd_rstn=%b want 1/0/0", int_n, bank, snd_rstn); end
    total++; if (rom_cs !== 1'b0 || cpu_din !== 8'hFF) begin bad++; $display("FAIL rstmid_bus rom_cs=%b cpu_din=%h want 0/ff", rom_cs, cpu_din); end
    bk = 0; snd = 0;
    lvbl = 1; mreq_n = 1; @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (int_n !== 1'b1) begin bad++; $display("FAIL rstmid_post cyc=%0d got=%b want=1", i, int_n); end
    end
  endtask

  initial begin
    test_reset();
    test_shared_ram();
    test_decode();
    test_bank();
    test_irq();
    test_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
